// File: rtl/gigatron_pkg.sv
// gigatron_pkg
//   Shared constants and the arbiter state encoding for the Gigatron RAM
//   arbiter slice.
//   Contents:
//     ADDR_W      - RAM address width (16)
//     DATA_W      - RAM data width (8)
//     arb_state_t - host-port FSM encoding (IDLE=0, PEND=1, RDATA=2, ACK=3)
package gigatron_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      RDATA = 2'd2,
      ACK   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/gigatron_wait_timer.sv
// gigatron_wait_timer
//   Saturating 16-bit wait counter with a sticky expiry flag. Used by the
//   arbiter to flag host requests that wait too long for a free RAM port.
//   Ports:
//     clk_i      - clock (rising edge)
//     rst_i      - synchronous active-high reset
//     clear_i    - restart the count from zero (entry into the wait state)
//     count_en_i - one more cycle spent waiting
//     timeout_o  - sticky flag, set when the count reaches TIMEOUT
//   Parameter TIMEOUT: 1..65535.
module gigatron_wait_timer #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic count_en_i,
   output logic timeout_o
);

   localparam logic [15:0] LIMIT = 16'(TIMEOUT);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        flag_q;
   logic        flag_d;

   // Next-state: count saturates at all-ones so it can never wrap back
   // below LIMIT; the flag is set from cnt_d so it is visible on the cycle
   // the count reaches LIMIT.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clear_i) begin
         cnt_d = 16'h0000;
      end else if (count_en_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'h0001;
      end else begin
         cnt_d = cnt_q;
      end
      if (count_en_i && (cnt_d == LIMIT)) begin
         flag_d = 1'b1;
      end else begin
         flag_d = flag_q;
      end
   end

   // Counter and sticky flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= 16'h0000;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign timeout_o = flag_q;

endmodule

// File: rtl/gigatron_ram_arbiter.sv
// gigatron_ram_arbiter
//   Shares the Gigatron's one-read/one-write-port RAM between the CPU and a
//   host (loader/debug) port. The CPU always wins; the host issues one access
//   at a time only in cycles where the CPU leaves the needed port idle.
//   Ports:
//     i_clock, i_reset                 - clock, synchronous active-high reset
//     i_cpu_raddr/i_cpu_re             - CPU read port request
//     i_cpu_waddr/i_cpu_we/i_cpu_wdata - CPU write port request
//     o_cpu_rdata                      - RAM read data to the CPU
//     i_host_req/_we/_addr/_wdata      - host request strobe and payload
//     o_host_busy/o_host_ack           - host handshake
//     o_host_rdata                     - captured host read data
//     o_host_timeout                   - sticky wait-timeout flag
//     o_ram_raddr/o_ram_waddr/o_ram_we/o_ram_wdata/i_ram_rdata - RAM side
//   Optional feature: define GIGATRON_RAM_ARB_TIMEOUT_EN to build the wait
//   timer; otherwise o_host_timeout is tied low.
import gigatron_pkg::*;

module gigatron_ram_arbiter #(
   parameter int unsigned HOST_TIMEOUT = 1024
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic [ADDR_W-1:0] i_cpu_raddr,
   input  logic              i_cpu_re,
   input  logic [ADDR_W-1:0] i_cpu_waddr,
   input  logic              i_cpu_we,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_host_req,
   input  logic              i_host_we,
   input  logic [ADDR_W-1:0] i_host_addr,
   input  logic [DATA_W-1:0] i_host_wdata,
   output logic              o_host_busy,
   output logic              o_host_ack,
   output logic [DATA_W-1:0] o_host_rdata,
   output logic              o_host_timeout,
   output logic [ADDR_W-1:0] o_ram_raddr,
   output logic [ADDR_W-1:0] o_ram_waddr,
   output logic              o_ram_we,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              host_we_q;
   logic [ADDR_W-1:0] host_addr_q;
   logic [DATA_W-1:0] host_wdata_q;
   logic [DATA_W-1:0] host_rdata_q;

   logic              latch_s;
   logic              capture_s;
   logic              wr_slot_s;
   logic              rd_slot_s;
   logic              host_wr_s;
   logic              host_rd_s;

   // FSM next state; a request presented while busy is simply not looked at.
   always_comb begin
      state_d   = state_q;
      latch_s   = 1'b0;
      capture_s = 1'b0;
      wr_slot_s = 1'b0;
      rd_slot_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_host_req) begin
               latch_s = 1'b1;
               state_d = PEND;
            end else begin
               state_d = IDLE;
            end
         end
         PEND: begin
            if (host_we_q) begin
               if (!i_cpu_we) begin
                  wr_slot_s = 1'b1;
                  state_d   = ACK;
               end else begin
                  state_d = PEND;
               end
            end else begin
               if (!i_cpu_re) begin
                  rd_slot_s = 1'b1;
                  state_d   = RDATA;
               end else begin
                  state_d = PEND;
               end
            end
         end
         RDATA: begin
            capture_s = 1'b1;
            state_d   = ACK;
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A host access never reaches the RAM in a reset cycle, even though the
   // FSM may be sitting in PEND with a free port.
   assign host_wr_s = wr_slot_s & ~i_reset;
   assign host_rd_s = rd_slot_s & ~i_reset;

   // FSM state, latched request and captured read data.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= IDLE;
         host_we_q    <= 1'b0;
         host_addr_q  <= 16'h0000;
         host_wdata_q <= 8'h00;
         host_rdata_q <= 8'h00;
      end else begin
         state_q <= state_d;
         if (latch_s) begin
            host_we_q    <= i_host_we;
            host_addr_q  <= i_host_addr;
            host_wdata_q <= i_host_wdata;
         end else begin
            host_we_q    <= host_we_q;
            host_addr_q  <= host_addr_q;
            host_wdata_q <= host_wdata_q;
         end
         if (capture_s) begin
            host_rdata_q <= i_ram_rdata;
         end else begin
            host_rdata_q <= host_rdata_q;
         end
      end
   end

   // RAM port muxing: the CPU path is combinational so it sees no latency;
   // the host only takes a port the CPU is not using this cycle.
   assign o_ram_raddr = host_rd_s ? host_addr_q  : i_cpu_raddr;
   assign o_ram_waddr = host_wr_s ? host_addr_q  : i_cpu_waddr;
   assign o_ram_wdata = host_wr_s ? host_wdata_q : i_cpu_wdata;
   assign o_ram_we    = i_cpu_we | host_wr_s;
   assign o_cpu_rdata = i_ram_rdata;

   assign o_host_busy  = (state_q != IDLE);
   assign o_host_ack   = (state_q == ACK);
   assign o_host_rdata = host_rdata_q;

`ifdef GIGATRON_RAM_ARB_TIMEOUT_EN
   logic pend_enter_s;
   logic pend_stay_s;

   assign pend_enter_s = (state_q != PEND) && (state_d == PEND);
   assign pend_stay_s  = (state_q == PEND) && (state_d == PEND);

   gigatron_wait_timer #(
      .TIMEOUT (HOST_TIMEOUT)
   ) u_wait_timer (
      .clk_i      (i_clock),
      .rst_i      (i_reset),
      .clear_i    (pend_enter_s),
      .count_en_i (pend_stay_s),
      .timeout_o  (o_host_timeout)
   );
`else
   localparam bit unused_host_timeout_s = (HOST_TIMEOUT > 0);
   assign o_host_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gigatron_ram_arbiter.sv
// tb_gigatron_ram_arbiter
//   Self-checking bench for gigatron_ram_arbiter with a behavioural RAM
//   (registered read, write-through on same-cycle address match).
module tb_gigatron_ram_arbiter;

   localparam logic [15:0] CPU_RADDR = 16'h7FFF;
   localparam logic [15:0] CPU_WADDR = 16'h7FF0;
   localparam logic [7:0]  CPU_WDATA = 8'hEE;

   logic        clk;
   logic        rst;
   logic [15:0] cpu_raddr;
   logic        cpu_re;
   logic [15:0] cpu_waddr;
   logic        cpu_we;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        host_req;
   logic        host_we;
   logic [15:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_busy;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_timeout;
   logic [15:0] ram_raddr;
   logic [15:0] ram_waddr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   gigatron_ram_arbiter #(.HOST_TIMEOUT(8)) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .i_cpu_raddr    (cpu_raddr),
      .i_cpu_re       (cpu_re),
      .i_cpu_waddr    (cpu_waddr),
      .i_cpu_we       (cpu_we),
      .i_cpu_wdata    (cpu_wdata),
      .o_cpu_rdata    (cpu_rdata),
      .i_host_req     (host_req),
      .i_host_we      (host_we),
      .i_host_addr    (host_addr),
      .i_host_wdata   (host_wdata),
      .o_host_busy    (host_busy),
      .o_host_ack     (host_ack),
      .o_host_rdata   (host_rdata),
      .o_host_timeout (host_timeout),
      .o_ram_raddr    (ram_raddr),
      .o_ram_waddr    (ram_waddr),
      .o_ram_we       (ram_we),
      .o_ram_wdata    (ram_wdata),
      .i_ram_rdata    (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: write at the edge, read data one cycle after address.
   logic [7:0] mem [0:65535];
   always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : mem[ram_raddr];
   end

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          block;
      logic [7:0]  exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_we = 1'b1; cpu_waddr = a; cpu_wdata = d;
      @(negedge clk);
      cpu_we = 1'b0; cpu_waddr = CPU_WADDR; cpu_wdata = CPU_WDATA;
   endtask

   task automatic cpu_read_check(input string name, input logic [15:0] a, input logic [7:0] exp);
      @(negedge clk);
      cpu_re = 1'b1; cpu_raddr = a;
      @(negedge clk);
      #1 chk(name, cpu_rdata, exp);
      cpu_re = 1'b0; cpu_raddr = CPU_RADDR;
   endtask

   // One host transaction with the CPU occupying the needed port for
   // 'block' cycles after the request.
   task automatic host_txn(input string name, input vec_t v);
      int  k;
      bit  done;
      @(negedge clk);
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
      k = 0; done = 1'b0;
      while (!done && (k < 60)) begin
         @(negedge clk);
         k++;
         host_req = 1'b0;
         if (v.we) cpu_we = (k <= v.block);
         else      cpu_re = (k <= v.block);
         #1;
         if (k <= v.block) begin
            if (v.we) chk({name, " cpu_keeps_wport"}, ram_waddr, CPU_WADDR);
            else      chk({name, " cpu_keeps_rport"}, ram_raddr, CPU_RADDR);
         end
         if (k == v.block + 1) begin
            if (v.we) begin
               chk({name, " issue_we"}, ram_we, 1'b1);
               chk({name, " issue_waddr"}, ram_waddr, v.addr);
               chk({name, " issue_wdata"}, ram_wdata, v.wdata);
            end else begin
               chk({name, " issue_raddr"}, ram_raddr, v.addr);
            end
         end
         if (host_ack) begin
            done = 1'b1;
            chk({name, " latency"}, k, v.exp_lat);
            if (!v.we) chk({name, " rdata"}, host_rdata, v.exp_rdata);
         end
      end
      if (!done) chk({name, " ack_wait_expired"}, 1'b0, 1'b1);
      @(negedge clk);
      #1 chk({name, " busy_after_ack"}, host_busy, 1'b0);
   endtask

   initial begin
      int ack_cnt;
      int ack_k;
      int first_to;
      bit bad_we;

      vecs[0] = '{1'b1, 16'h1234, 8'hA5, 0, 8'h00, 2};
      vecs[1] = '{1'b0, 16'h1234, 8'h00, 0, 8'hA5, 3};
      vecs[2] = '{1'b0, 16'h0080, 8'h00, 5, 8'h3C, 8};
      vecs[3] = '{1'b1, 16'hBEEF, 8'h77, 3, 8'h00, 5};
      vecs[4] = '{1'b0, 16'hBEEF, 8'h00, 1, 8'h77, 4};
      vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 0, 8'h99, 3};
      vecs[6] = '{1'b1, 16'h0000, 8'h01, 0, 8'h00, 2};
      vecs[7] = '{1'b0, 16'h0000, 8'h00, 2, 8'h01, 5};

      rst = 1'b1; cpu_re = 1'b0; cpu_we = 1'b0;
      cpu_raddr = CPU_RADDR; cpu_waddr = CPU_WADDR; cpu_wdata = CPU_WDATA;
      host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("reset busy", host_busy, 1'b0);
      chk("reset ack", host_ack, 1'b0);
      chk("reset rdata", host_rdata, 8'h00);
      chk("reset timeout", host_timeout, 1'b0);
      rst = 1'b0;

      cpu_write(16'h0080, 8'h3C);
      cpu_write(16'h0020, 8'h5A);
      cpu_write(16'hFFFF, 8'h99);
      cpu_write(16'h0055, 8'h00);
      cpu_write(16'h0300, 8'h00);
      cpu_write(16'h0010, 8'h00);
      cpu_write(16'h0400, 8'h00);

      for (int i = 0; i < 8; i++) host_txn($sformatf("vec%0d", i), vecs[i]);

      cpu_read_check("cpu_read_after_host_write", 16'h1234, 8'hA5);

      // Host read issues while the CPU writes elsewhere in the same cycle.
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
      @(negedge clk);
      host_req = 1'b0; cpu_we = 1'b1; cpu_waddr = 16'h0010; cpu_wdata = 8'h11;
      #1;
      chk("same_cycle ram_we", ram_we, 1'b1);
      chk("same_cycle waddr", ram_waddr, 16'h0010);
      chk("same_cycle wdata", ram_wdata, 8'h11);
      chk("same_cycle raddr", ram_raddr, 16'h0020);
      @(negedge clk);
      cpu_we = 1'b0; cpu_waddr = CPU_WADDR; cpu_wdata = CPU_WDATA;
      #1 chk("same_cycle early_ack", host_ack, 1'b0);
      @(negedge clk);
      #1;
      chk("same_cycle ack", host_ack, 1'b1);
      chk("same_cycle rdata", host_rdata, 8'h5A);
      cpu_read_check("same_cycle cpu_write_landed", 16'h0010, 8'h11);

      // Second request while busy must be ignored.
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0080;
      ack_cnt = 0; ack_k = 0; bad_we = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         cpu_re = (k <= 3);
         if (k == 2) begin
            host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0055; host_wdata = 8'hEE;
         end else begin
            host_req = 1'b0;
         end
         #1;
         if (ram_we) bad_we = 1'b1;
         if (host_ack) begin
            ack_cnt++;
            ack_k = k;
            chk("busy_drop rdata", host_rdata, 8'h3C);
         end
         if ((ack_k != 0) && (k == ack_k + 1)) chk("busy_drop busy_fall", host_busy, 1'b0);
      end
      chk("busy_drop ack_count", ack_cnt, 1);
      chk("busy_drop ack_cycle", ack_k, 6);
      chk("busy_drop no_write", bad_we, 1'b0);
      cpu_read_check("busy_drop mem_untouched", 16'h0055, 8'h00);

      // Long-blocked write: timeout behaviour.
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0400; host_wdata = 8'h42;
      first_to = 0; ack_k = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         host_req = 1'b0;
         cpu_we = (k <= 20);
         #1;
         if (host_timeout && (first_to == 0)) first_to = k;
         if (host_ack) ack_k = k;
      end
      chk("timeout ack_cycle", ack_k, 22);
`ifdef GIGATRON_RAM_ARB_TIMEOUT_EN
      chk("timeout rise_cycle", first_to, 9);
      chk("timeout sticky", host_timeout, 1'b1);
`else
      chk("timeout never", first_to, 0);
      chk("timeout tied_low", host_timeout, 1'b0);
`endif
      cpu_read_check("timeout write_landed", 16'h0400, 8'h42);

      // Reset in PEND, in the very cycle the write port frees up.
      @(negedge clk);
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0300; host_wdata = 8'hDD;
      @(negedge clk);
      host_req = 1'b0; cpu_we = 1'b1;
      @(negedge clk);
      @(negedge clk);
      cpu_we = 1'b0; rst = 1'b1;
      #1 chk("reset_mid no_issue", ram_we, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_mid busy", host_busy, 1'b0);
      chk("reset_mid ack", host_ack, 1'b0);
      chk("reset_mid rdata", host_rdata, 8'h00);
      chk("reset_mid timeout", host_timeout, 1'b0);
      @(negedge clk);
      #1;
      chk("reset_mid still_no_write", ram_we, 1'b0);
      chk("reset_mid still_idle", host_busy, 1'b0);
      cpu_read_check("reset_mid mem_untouched", 16'h0300, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
